// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic REQ_RX  = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int PROTECTED_REGS_DEFAULT = 4;

    // Rd_Timeout is limited to 1..15, so four bits always suffice.
    localparam int TMO_CNT_W = 4;

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter_2.sv
// Two-way round-robin pick; the requester not granted last wins a tie.
// Latency: combinational.
// Backpressure: none, grant follows valid inputs directly.
module rr_arbiter_2
    import reg_file_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && (!valid1 || last_grant == REQ_DBG)) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Serializes two requesters onto the single-port register file.
// Latency: strobe at k+1, write resp k+2, read resp k+3+wait (timeout k+2+Rd_Timeout).
// Backpressure: Ready only in IDLE toward the round-robin winner.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int Data_width     = 8,
    parameter int REG_File_Depth = 16,
    parameter int Address_Depth  = $clog2(REG_File_Depth),
    parameter int Rd_Timeout     = 4,
    parameter int Protected_Regs = PROTECTED_REGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Req0_Valid,
    input  logic                     Req0_Wr,
    input  logic [Address_Depth-1:0] Req0_Addr,
    input  logic [Data_width-1:0]    Req0_WrData,
    output logic                     Req0_Ready,
    output logic                     Req0_Resp_Valid,
    output logic [Data_width-1:0]    Req0_RdData,
    output logic                     Req0_Err,
    input  logic                     Req1_Valid,
    input  logic                     Req1_Wr,
    input  logic [Address_Depth-1:0] Req1_Addr,
    input  logic [Data_width-1:0]    Req1_WrData,
    output logic                     Req1_Ready,
    output logic                     Req1_Resp_Valid,
    output logic [Data_width-1:0]    Req1_RdData,
    output logic                     Req1_Err,
    output logic [Address_Depth-1:0] REG_Address,
    output logic                     REG_WrEn,
    output logic                     REG_RdEn,
    output logic [Data_width-1:0]    REG_WrData,
    input  logic [Data_width-1:0]    REG_RdData,
    input  logic                     REG_Rd_Valid
);

    localparam logic [Address_Depth:0] PROT_LIMIT = (Address_Depth + 1)'(Protected_Regs);
    localparam logic [TMO_CNT_W-1:0]  TMO_LIMIT  = TMO_CNT_W'(Rd_Timeout);

    state_t                   state;
    state_t                   state_nxt;
    logic [1:0]               grant;
    logic                     sel;
    logic                     accept;
    logic                     last_grant;
    logic                     owner;
    logic                     cap_wr;
    logic                     prot_err;
    logic [TMO_CNT_W-1:0]     cnt;
    logic                     tmo_hit;
    logic [Data_width-1:0]    resp_data;
    logic                     resp_err;
    logic                     req_wr;
    logic [Address_Depth-1:0] req_addr;
    logic [Data_width-1:0]    req_wdata;
    logic                     req_prot;

    rr_arbiter_2 u_rr_arbiter_2 (
        .valid0     (Req0_Valid),
        .valid1     (Req1_Valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel       = grant[1];
    assign accept    = (state == IDLE) && rst && (grant != 2'b00);
    assign req_wr    = sel ? Req1_Wr     : Req0_Wr;
    assign req_addr  = sel ? Req1_Addr   : Req0_Addr;
    assign req_wdata = sel ? Req1_WrData : Req0_WrData;
    // Low addresses belong to the UART controller; the debug master may only read them.
    assign req_prot  = req_wr && (sel == REQ_DBG) && ({1'b0, req_addr} < PROT_LIMIT);
    assign tmo_hit   = (cnt + 1'b1) == TMO_LIMIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = cap_wr ? RESP : WAIT_RD;
            WAIT_RD: if (REG_Rd_Valid || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Req0_Ready      = (state == IDLE) && rst && grant[0];
        Req1_Ready      = (state == IDLE) && rst && grant[1];
        Req0_Resp_Valid = (state == RESP) && (owner == REQ_RX);
        Req1_Resp_Valid = (state == RESP) && (owner == REQ_DBG);
        Req0_RdData     = Req0_Resp_Valid ? resp_data : '0;
        Req1_RdData     = Req1_Resp_Valid ? resp_data : '0;
        Req0_Err        = Req0_Resp_Valid && resp_err;
        Req1_Err        = Req1_Resp_Valid && resp_err;
    end

    // Strobe registers are loaded on acceptance so they are high only during ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            REG_Address <= '0;
            REG_WrEn    <= 1'b0;
            REG_RdEn    <= 1'b0;
            REG_WrData  <= '0;
            owner       <= REQ_RX;
            cap_wr      <= 1'b0;
            prot_err    <= 1'b0;
            cnt         <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            last_grant  <= REQ_DBG;
        end else begin
            REG_Address <= '0;
            REG_WrEn    <= 1'b0;
            REG_RdEn    <= 1'b0;
            REG_WrData  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner       <= sel;
                        cap_wr      <= req_wr;
                        prot_err    <= req_prot;
                        REG_Address <= req_addr;
                        REG_WrEn    <= req_wr && !req_prot;
                        REG_RdEn    <= !req_wr;
                        REG_WrData  <= req_wr ? req_wdata : '0;
                    end
                end
                ACCESS: begin
                    if (cap_wr) begin
                        resp_data <= '0;
                        resp_err  <= prot_err;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_RD: begin
                    if (REG_Rd_Valid) begin
                        resp_data <= REG_RdData;
                        resp_err  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (tmo_hit) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench: requests are predicted at acceptance, a negedge monitor checks
// strobes, grants and responses cycle-exactly against a register-file model.
module tb_reg_file_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int T  = 4;
    localparam int PR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          Req0_Valid, Req0_Wr, Req0_Ready, Req0_Resp_Valid, Req0_Err;
    logic [AW-1:0] Req0_Addr;
    logic [DW-1:0] Req0_WrData, Req0_RdData;
    logic          Req1_Valid, Req1_Wr, Req1_Ready, Req1_Resp_Valid, Req1_Err;
    logic [AW-1:0] Req1_Addr;
    logic [DW-1:0] Req1_WrData, Req1_RdData;
    logic [AW-1:0] REG_Address;
    logic          REG_WrEn, REG_RdEn, REG_Rd_Valid;
    logic [DW-1:0] REG_WrData, REG_RdData;

    always #5 clk = ~clk;

    reg_file_arbiter #(
        .Data_width(DW), .REG_File_Depth(16), .Address_Depth(AW),
        .Rd_Timeout(T), .Protected_Regs(PR)
    ) dut (
        .clk(clk), .rst(rst),
        .Req0_Valid(Req0_Valid), .Req0_Wr(Req0_Wr), .Req0_Addr(Req0_Addr),
        .Req0_WrData(Req0_WrData), .Req0_Ready(Req0_Ready),
        .Req0_Resp_Valid(Req0_Resp_Valid), .Req0_RdData(Req0_RdData), .Req0_Err(Req0_Err),
        .Req1_Valid(Req1_Valid), .Req1_Wr(Req1_Wr), .Req1_Addr(Req1_Addr),
        .Req1_WrData(Req1_WrData), .Req1_Ready(Req1_Ready),
        .Req1_Resp_Valid(Req1_Resp_Valid), .Req1_RdData(Req1_RdData), .Req1_Err(Req1_Err),
        .REG_Address(REG_Address), .REG_WrEn(REG_WrEn), .REG_RdEn(REG_RdEn),
        .REG_WrData(REG_WrData), .REG_RdData(REG_RdData), .REG_Rd_Valid(REG_Rd_Valid)
    );

    typedef struct {int due; bit owner; logic [DW-1:0] data; bit err;} rsp_t;
    typedef struct {int due; bit wr_en; bit rd_en; logic [AW-1:0] addr; logic [DW-1:0] data;} stb_t;

    rsp_t          rq[$];
    stb_t          sq[$];
    int            glog[$];
    logic [DW-1:0] model_mem[16];
    logic [DW-1:0] rf_mem[16];
    logic [AW-1:0] rd_addr;
    int            tests = 0, fails = 0;
    int            cyc = 0;
    bit            lg;
    int            busy_until, rd_valid_cyc, win_lo, win_hi, forced_delay;
    bit            acc0, acc1, stray_en, hold_mode;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares everything the DUT presents, then predicts any new acceptance.
    always @(negedge clk) begin : monitor
        rsp_t e;
        stb_t s;
        bit   idle, own, wr, prot;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int   d;
        if (rst) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                check("resp_valid", e.owner ? Req1_Resp_Valid : Req0_Resp_Valid, 1);
                check("resp_other_quiet", e.owner ? {Req0_Resp_Valid, Req0_RdData, Req0_Err}
                                                  : {Req1_Resp_Valid, Req1_RdData, Req1_Err}, 0);
                check("resp_rddata", e.owner ? Req1_RdData : Req0_RdData, e.data);
                check("resp_err", e.owner ? Req1_Err : Req0_Err, e.err);
                lg = e.owner;
                glog.push_back(int'(e.owner));
            end else begin
                check("no_resp", {Req0_Resp_Valid, Req1_Resp_Valid}, 0);
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                s = sq.pop_front();
                check("reg_wren", REG_WrEn, s.wr_en);
                check("reg_rden", REG_RdEn, s.rd_en);
                check("reg_addr", REG_Address, s.addr);
                if (s.wr_en) check("reg_wrdata", REG_WrData, s.data);
            end else begin
                check("no_strobe", {REG_WrEn, REG_RdEn}, 0);
            end
            if (REG_WrEn) rf_mem[REG_Address] = REG_WrData;
            if (REG_RdEn) rd_addr = REG_Address;

            idle = cyc > busy_until;
            check("ready", {Req1_Ready, Req0_Ready},
                  {idle && Req1_Valid && (!Req0_Valid || !lg), idle && Req0_Valid && (!Req1_Valid || lg)});

            if ((Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready)) begin
                own = Req1_Valid && Req1_Ready;
                wr  = own ? Req1_Wr : Req0_Wr;
                a   = own ? Req1_Addr : Req0_Addr;
                wd  = own ? Req1_WrData : Req0_WrData;
                if (own) acc1 = 1; else acc0 = 1;
                s.due = cyc + 1; s.addr = a; s.data = wd;
                e.owner = own;
                if (wr) begin
                    prot = own && (int'(a) < PR);
                    s.wr_en = !prot; s.rd_en = 0;
                    e.due = cyc + 2; e.data = '0; e.err = prot;
                    if (!prot) model_mem[a] = wd;
                end else begin
                    d = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, T + 1));
                    s.wr_en = 0; s.rd_en = 1;
                    if (d < T) begin
                        e.due = cyc + 3 + d; e.data = model_mem[a]; e.err = 0;
                        rd_valid_cyc = cyc + 2 + d;
                    end else begin
                        e.due = cyc + 2 + T; e.data = '0; e.err = 1;
                        rd_valid_cyc = -1;
                    end
                    win_lo = cyc + 2;
                    win_hi = e.due - 1;
                end
                busy_until = e.due;
                sq.push_back(s);
                rq.push_back(e);
            end
        end
    end

    task automatic new_req(input int r);
        if (r == 0) begin
            Req0_Valid = 1; Req0_Wr = 1'($urandom_range(0, 1));
            Req0_Addr = AW'($urandom_range(0, 15)); Req0_WrData = DW'($urandom);
        end else begin
            Req1_Valid = 1; Req1_Wr = 1'($urandom_range(0, 1));
            Req1_Addr = AW'($urandom_range(0, 15)); Req1_WrData = DW'($urandom);
        end
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin Req0_Valid = 1; Req0_Wr = wr; Req0_Addr = a; Req0_WrData = d; end
        else        begin Req1_Valid = 1; Req1_Wr = wr; Req1_Addr = a; Req1_WrData = d; end
    endtask

    // One clock: retire accepted requests and drive the register-file read side.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0) begin acc0 = 0; if (hold_mode) new_req(0); else Req0_Valid = 0; end
        if (acc1) begin acc1 = 0; if (hold_mode) new_req(1); else Req1_Valid = 0; end
        if (cyc == rd_valid_cyc) begin
            REG_Rd_Valid = 1; REG_RdData = rf_mem[rd_addr];
        end else begin
            REG_Rd_Valid = stray_en && (cyc < win_lo || cyc > win_hi) && ($urandom_range(0, 3) == 0);
            REG_RdData   = DW'($urandom);
        end
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((Req0_Valid || Req1_Valid || cyc <= busy_until) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL wait_budget: still busy after %0d cycles, required idle", n);
            Req0_Valid = 0; Req1_Valid = 0;
        end
    endtask

    initial begin
        int n, base;
        rst = 0; Req0_Valid = 0; Req1_Valid = 0; REG_Rd_Valid = 0; REG_RdData = '0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = DW'(i * 17 + 3);
            rf_mem[i]    = DW'(i * 17 + 3);
        end
        lg = 1; busy_until = -1; rd_valid_cyc = -1; win_lo = 1; win_hi = 0;
        forced_delay = -1; stray_en = 0; hold_mode = 1; acc0 = 0; acc1 = 0;
        new_req(0); new_req(1);
        #2;
        check("reset_ready", {Req1_Ready, Req0_Ready}, 0);
        check("reset_outs", {REG_WrEn, REG_RdEn, REG_Address, REG_WrData, Req0_Resp_Valid, Req1_Resp_Valid}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Both requesters held valid from reset: strict alternation starting at 0.
        n = 0;
        while (glog.size() < 4 && n < 200) begin tick(); n++; end
        hold_mode = 0; Req0_Valid = 0; Req1_Valid = 0;
        run_until_done(50);
        check("tie_count", glog.size() >= 4, 1);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("tie_order", glog[i], i % 2);

        set_req(0, 1, 4'd5, 8'h3C);          run_until_done(20);
        set_req(0, 1, 4'd2, 8'hA7);          run_until_done(20);
        forced_delay = 0;
        set_req(1, 0, 4'd2, 8'h00);          run_until_done(20);
        set_req(1, 1, 4'd1, 8'h55);          run_until_done(20);
        set_req(0, 1, 4'd1, 8'h66);          run_until_done(20);
        forced_delay = 1;
        set_req(1, 0, 4'd1, 8'h00);          run_until_done(20);
        forced_delay = 100; stray_en = 1;
        set_req(0, 0, 4'd7, 8'h00);          run_until_done(30);
        repeat (8) tick();

        forced_delay = -1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (!Req0_Valid && $urandom_range(0, 2) == 0) new_req(0);
            else if (Req0_Valid && $urandom_range(0, 19) == 0) Req0_Valid = 0;
            if (!Req1_Valid && $urandom_range(0, 2) == 0) new_req(1);
            else if (Req1_Valid && $urandom_range(0, 19) == 0) Req1_Valid = 0;
        end
        Req0_Valid = 0; Req1_Valid = 0;
        run_until_done(50);

        // Reset while waiting for read data: everything clears, nothing is answered.
        stray_en = 0; forced_delay = 100;
        set_req(1, 0, 4'd3, 8'h00);
        n = 0;
        while (Req1_Valid && n < 20) begin tick(); n++; end
        check("rst_read_accepted", Req1_Valid, 0);
        tick();
        rst = 0;
        #1;
        check("rst_outs", {REG_WrEn, REG_RdEn, REG_Address, REG_WrData}, 0);
        check("rst_resp", {Req0_Resp_Valid, Req0_RdData, Req0_Err, Req1_Resp_Valid, Req1_RdData, Req1_Err}, 0);
        rq.delete(); sq.delete();
        lg = 1; busy_until = -1; rd_valid_cyc = -1; win_lo = 1; win_hi = 0; acc0 = 0; acc1 = 0;
        set_req(0, 1, 4'd9, 8'h11); set_req(1, 1, 4'd10, 8'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_quiet", {Req0_Ready, Req1_Ready, Req0_Resp_Valid, Req1_Resp_Valid}, 0);
        end
        base = glog.size();
        rst = 1;
        run_until_done(40);
        check("post_rst_count", glog.size() - base, 2);
        if (glog.size() > base) check("post_rst_first", glog[base], 0);

        repeat (3) tick();
        check("queues_drained", rq.size() + sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-requester arbiter that shares the single-port register file between the UART command controller (requester 0) and a second configuration/debug master (requester 1). It serializes accesses, drives the register file strobes, waits for read data with a bounded timeout, and returns a one-cycle response to the owning requester. It sits between the requesters and the register file in the REF_CLK domain.

## Interface
- Data_width, 8, register data width
- REG_File_Depth, 16, number of registers
- Address_Depth, $clog2(REG_File_Depth), address width
- Rd_Timeout, 4, WAIT_RD cycles before a read is aborted with error (range 1..15)
- Protected_Regs, 4, addresses below this value are writable only by requester 0
- clk  input  1  REF_CLK domain clock
- rst  input  1  asynchronous, active-low reset
- Req0_Valid / Req1_Valid  input  1  request pending; held until accepted
- Req0_Wr / Req1_Wr  input  1  1 = write, 0 = read
- Req0_Addr / Req1_Addr  input  Address_Depth  register address
- Req0_WrData / Req1_WrData  input  Data_width  write data
- Req0_Ready / Req1_Ready  output  1  grant; request is accepted when Valid & Ready
- Req0_Resp_Valid / Req1_Resp_Valid  output  1  one-cycle response pulse
- Req0_RdData / Req1_RdData  output  Data_width  read data, valid with Resp_Valid
- Req0_Err / Req1_Err  output  1  error flag, valid with Resp_Valid
- REG_Address  output  Address_Depth  register file address
- REG_WrEn  output  1  register file write strobe
- REG_RdEn  output  1  register file read strobe
- REG_WrData  output  Data_width  register file write data
- REG_RdData  input  Data_width  register file read data
- REG_Rd_Valid  input  1  register file read-data valid

## Operation
- FSM states: IDLE, ACCESS, WAIT_RD, RESP.
- IDLE: Ready is combinational and asserted only toward the winner. On Valid & Ready, capture Wr/Addr/WrData/owner, then go to ACCESS.
- Arbitration: a single Valid wins. If both are Valid, the winner is the requester not granted last (last_grant pointer).
- ACCESS (1 cycle): registered outputs drive REG_Address plus either REG_WrEn with REG_WrData, or REG_RdEn.
  - Write then goes to RESP.
  - Read goes to WAIT_RD with the timeout counter cleared.
- Protected write (owner = 1, Addr < Protected_Regs): no REG_WrEn is issued; go to RESP with Err = 1.
- WAIT_RD:
  - REG_Rd_Valid = 1: capture REG_RdData and go to RESP with Err = 0.
  - Otherwise increment the counter. When it reaches Rd_Timeout, go to RESP with Err = 1 and RdData = 0.
- RESP (1 cycle): pulse the owner's Resp_Valid with RdData/Err (RdData = 0 for writes), update last_grant = owner, and return to IDLE.
- The non-owner's Resp_Valid, RdData and Err stay 0.
- REG_Rd_Valid outside WAIT_RD is ignored.
- A Valid dropped before acceptance has no effect.

## Timing
- Reset state:
  - state IDLE, last_grant = 1 (so requester 0 wins the first tie), counter 0.
  - All registered outputs 0; Ready = 0 while rst is asserted.
- Reset mid-operation aborts the access; no response is issued.
- Acceptance in cycle k:
  - REG strobes high for exactly one cycle, k+1.
  - Write or protected-write response in cycle k+2.
  - Read response in cycle k+3 when REG_Rd_Valid arrives in k+2. Each missing valid cycle adds one cycle.
  - Timeout response in cycle k+2+Rd_Timeout.
- Ready = 0 in ACCESS, WAIT_RD and RESP. The next acceptance can occur at the earliest one cycle after RESP.
- Write throughput: one access per 3 cycles under back-to-back alternating requests.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE = 0, ACCESS = 1, WAIT_RD = 2, RESP = 3)
  - requester ID constants (REQ_RX = 0, REQ_DBG = 1)
  - the default Protected_Regs value
- One sub-module, rr_arbiter_2: combinational two-way round-robin pick from {valid0, valid1, last_grant}, producing grant one-hot. The FSM, capture registers and counter stay in the top level.

## Test plan
- Req0 write addr 5 data 0x3C → REG_WrEn = 1 with REG_Address = 5, REG_WrData = 0x3C in k+1; Req0_Resp_Valid in k+2 with Err = 0.
- Req1 read addr 2, register file returns 0xA7 one cycle after RdEn → Req1_Resp_Valid in k+3 with RdData = 0xA7, Err = 0.
- Both Valid held continuously, from reset → grant order 0, 1, 0, 1; no lost or duplicated responses.
- Req1 write addr 1 → no REG_WrEn ever asserted; Req1_Resp_Valid with Err = 1. The same write from Req0 succeeds.
- Read with REG_Rd_Valid never asserted, Rd_Timeout = 4 → response in k+6 with Err = 1, RdData = 0. A later stray REG_Rd_Valid is ignored.
- rst asserted during WAIT_RD → all outputs 0 immediately and no response pulse. After release, the next tie goes to requester 0.
